// File: rtl/adder_bist_ctrl.sv
// BIST sweep of every {cin,x,y} vector into a combinational adder, checked against a golden sum.
// Each vector takes SETTLE+1 cycles; there is no backpressure, and start is ignored while busy.
module adder_bist_ctrl #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     x_out,
    output logic [WIDTH-1:0]     y_out,
    output logic                 cin_out,
    input  logic [WIDTH-1:0]     s_in,
    input  logic                 cout_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic                 fail_valid,
    output logic [2*WIDTH:0]     fail_vec
);
    localparam int IDX_W = 2*WIDTH + 1;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [SET_W-1:0]   settle;
    logic [WIDTH:0]     golden;
    logic               mismatch;
    logic [ERR_W-1:0]   err_next;

    assign cin_out = idx[IDX_W-1];
    assign x_out   = idx[IDX_W-2:WIDTH];
    assign y_out   = idx[WIDTH-1:0];

    // Case-inequality so an X/Z from a broken adder is scored as a failure.
    always_comb begin
        golden   = {1'b0, x_out} + {1'b0, y_out} + {{WIDTH{1'b0}}, cin_out};
        mismatch = ({cout_in, s_in} !== golden);
        err_next = err_count;
        if (mismatch && !(&err_count))
            err_next = err_count + ERR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            settle     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx        <= '0;
                        settle     <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_vec   <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= APPLY;
                    end
                end
                APPLY: begin
                    if (settle == SET_W'(SETTLE - 1)) begin
                        settle <= '0;
                        state  <= CHECK;
                    end else begin
                        settle <= settle + SET_W'(1);
                    end
                end
                CHECK: begin
                    err_count <= err_next;
                    if (mismatch && !fail_valid) begin
                        fail_vec   <= idx;
                        fail_valid <= 1'b1;
                    end
                    // Stop on the last vector rather than wrapping idx.
                    if (&idx) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= DONE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Bench for adder_bist_ctrl: behavioural adders with optional stuck-at faults, scoreboard on done.
module tb_adder_bist_ctrl;
    localparam int SWEEP = 1536;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [3:0]  x, y, s, x4, y4, s4;
    logic        cin, cout, cin4, cout4;
    logic        busy, done, pass, fv;
    logic        busy4, done4, pass4, fv4;
    logic [15:0] err;
    logic [3:0]  err4;
    logic [8:0]  fvec, fvec4;
    logic [4:0]  sum, sum4;
    int          fault;

    typedef struct packed {
        logic [15:0] err;
        logic        pass;
        logic        fv;
        logic [8:0]  fvec;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, start_cyc = 0, busy_cnt = 0;
    logic done_q = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main AUT: fault 1 = s[1] stuck-at-0, fault 2 = cout stuck-at-0.
    always_comb begin
        sum  = 5'(x) + 5'(y) + 5'(cin);
        s    = sum[3:0];
        cout = sum[4];
        if (fault == 1) s[1] = 1'b0;
        if (fault == 2) cout = 1'b0;
        sum4  = 5'(x4) + 5'(y4) + 5'(cin4);
        s4    = sum4[3:0] & 4'b1101;
        cout4 = sum4[4];
    end

    adder_bist_ctrl #(.WIDTH(4), .SETTLE(2), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x_out(x), .y_out(y), .cin_out(cin), .s_in(s), .cout_in(cout),
        .busy(busy), .done(done), .pass(pass), .err_count(err),
        .fail_valid(fv), .fail_vec(fvec)
    );

    adder_bist_ctrl #(.WIDTH(4), .SETTLE(2), .ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start),
        .x_out(x4), .y_out(y4), .cin_out(cin4), .s_in(s4), .cout_in(cout4),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
        .fail_valid(fv4), .fail_vec(fvec4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Monitor: scores every rising edge of done against the queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
            done_q   = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done && !done_q) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("err_count",  32'(err),  32'(e.err));
                    check("pass",       32'(pass), 32'(e.pass));
                    check("fail_valid", 32'(fv),   32'(e.fv));
                    check("fail_vec",   32'(fvec), 32'(e.fvec));
                    check("latency",    32'(cyc - start_cyc), 32'(SWEEP));
                    check("busy_cycles", 32'(busy_cnt), 32'(SWEEP));
                    check("sat_done",     32'(done4), 32'd1);
                    check("sat_err",      32'(err4),  32'd15);
                    check("sat_fail_vec", 32'(fvec4), 32'h002);
                    check("sat_pass",     32'(pass4), 32'd0);
                end
                busy_cnt = 0;
            end
            done_q = done;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < SWEEP + 200; i++) begin
            if (done) break;
            @(negedge clk);
        end
        if (!done) begin
            check("done_timeout", 32'd0, 32'd1);
            if (q.size() > 0) void'(q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic run_sweep(input int f, input exp_t ex);
        fault = f;
        q.push_back(ex);
        pulse_start();
        wait_done();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_pass"},  32'(pass), 32'd0);
        check({tag, "_fv"},    32'(fv),   32'd0);
        check({tag, "_err"},   32'(err),  32'd0);
        check({tag, "_fvec"},  32'(fvec), 32'd0);
        check({tag, "_ops"},   32'({cin, x, y}), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        fault = 0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("idle");

        // Ideal adder, then s[1] stuck-at-0, then cout stuck-at-0.
        run_sweep(0, '{err: 16'd0,   pass: 1'b1, fv: 1'b0, fvec: 9'h000});
        run_sweep(1, '{err: 16'd256, pass: 1'b0, fv: 1'b1, fvec: 9'h002});
        run_sweep(2, '{err: 16'd256, pass: 1'b0, fv: 1'b1, fvec: 9'h01F});

        // Reset partway through a failing sweep discards everything.
        fault = 1;
        pulse_start();
        repeat (699) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_err_nonzero", 32'(err != 0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_idle("mid_rst");
        rst = 1'b0;
        run_sweep(1, '{err: 16'd256, pass: 1'b0, fv: 1'b1, fvec: 9'h002});

        // Start pulses while busy must not restart the sweep.
        fault = 0;
        q.push_back('{err: 16'd0, pass: 1'b1, fv: 1'b0, fvec: 9'h000});
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            repeat (200) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();

        // Start from DONE clears results and reruns.
        fault = 2;
        q.push_back('{err: 16'd256, pass: 1'b0, fv: 1'b1, fvec: 9'h01F});
        pulse_start();
        check("restart_done", 32'(done), 32'd0);
        check("restart_err",  32'(err),  32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        wait_done();

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
